// File: rtl/mm_host_controller.sv
// Host-side sequencer for matrix_multiplier: streams A and B into its memory, runs it,
// then streams result matrix C back out over a valid/ready interface.
module mm_host_controller #(
  parameter int N       = 4,
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 12,
  parameter int TIMEOUT = 65535
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] mm_data_in,
  output logic [ADDR_W-1:0] mm_address,
  output logic              mm_write_enable,
  output logic              mm_reset,
  input  logic [DATA_W-1:0] mm_data_out,
  input  logic              mm_result_ready,
  output logic              busy,
  output logic              done,
  output logic              timeout_err
);

  localparam int NN     = N * N;
  localparam int WAIT_W = $clog2(TIMEOUT + 1);

  localparam logic [ADDR_W-1:0] LOAD_LAST = ADDR_W'(2 * NN - 1);
  localparam logic [ADDR_W-1:0] READ_LAST = ADDR_W'(NN - 1);
  localparam logic [ADDR_W-1:0] C_BASE    = ADDR_W'(2 * NN);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_RUN, S_WAIT, S_RADDR, S_RCAP, S_OUT, S_FIN
  } state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] k, k_nxt;
  logic [WAIT_W-1:0] wait_cnt, wait_cnt_nxt;
  logic [DATA_W-1:0] out_data_nxt;
  logic              out_valid_nxt;
  logic [DATA_W-1:0] mm_data_in_nxt;
  logic [ADDR_W-1:0] mm_address_nxt;
  logic              mm_write_enable_nxt;
  logic              mm_reset_nxt;
  logic              timeout_err_nxt;

  assign in_ready = (state == S_LOAD);
  assign busy     = (state != S_IDLE);
  assign done     = (state == S_FIN);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= S_IDLE;
      k               <= '0;
      wait_cnt        <= '0;
      out_data        <= '0;
      out_valid       <= 1'b0;
      mm_data_in      <= '0;
      mm_address      <= '0;
      mm_write_enable <= 1'b0;
      mm_reset        <= 1'b1;
      timeout_err     <= 1'b0;
    end else begin
      state           <= state_nxt;
      k               <= k_nxt;
      wait_cnt        <= wait_cnt_nxt;
      out_data        <= out_data_nxt;
      out_valid       <= out_valid_nxt;
      mm_data_in      <= mm_data_in_nxt;
      mm_address      <= mm_address_nxt;
      mm_write_enable <= mm_write_enable_nxt;
      mm_reset        <= mm_reset_nxt;
      timeout_err     <= timeout_err_nxt;
    end
  end

  always_comb begin
    state_nxt           = state;
    k_nxt               = k;
    wait_cnt_nxt        = wait_cnt;
    out_data_nxt        = out_data;
    out_valid_nxt       = out_valid;
    mm_data_in_nxt      = mm_data_in;
    mm_address_nxt      = mm_address;
    mm_write_enable_nxt = 1'b0;
    timeout_err_nxt     = timeout_err;

    case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt       = S_LOAD;
          k_nxt           = '0;
          timeout_err_nxt = 1'b0;
        end
      end
      S_LOAD: begin
        if (in_valid) begin
          mm_address_nxt      = k;
          mm_data_in_nxt      = in_data;
          mm_write_enable_nxt = 1'b1;
          k_nxt               = k + 1'b1;
          if (k == LOAD_LAST) state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        wait_cnt_nxt = '0;
        state_nxt    = S_WAIT;
      end
      S_WAIT: begin
        if (mm_result_ready) begin
          state_nxt      = S_RADDR;
          k_nxt          = '0;
          mm_address_nxt = C_BASE;
        end else if (wait_cnt == WAIT_LAST) begin
          state_nxt       = S_FIN;
          timeout_err_nxt = 1'b1;
        end else begin
          wait_cnt_nxt = wait_cnt + 1'b1;
        end
      end
      S_RADDR: begin
        state_nxt = S_RCAP;
      end
      S_RCAP: begin
        out_data_nxt  = mm_data_out;
        out_valid_nxt = 1'b1;
        state_nxt     = S_OUT;
      end
      S_OUT: begin
        if (out_ready) begin
          out_valid_nxt = 1'b0;
          k_nxt         = k + 1'b1;
          if (k == READ_LAST) begin
            state_nxt = S_FIN;
          end else begin
            state_nxt      = S_RADDR;
            mm_address_nxt = C_BASE + k + 1'b1;
          end
        end
      end
      S_FIN: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase

    // The engine runs only while a job owns it; its reset is driven from the upcoming state.
    case (state_nxt)
      S_RUN, S_WAIT, S_RADDR, S_RCAP, S_OUT: mm_reset_nxt = 1'b0;
      default:                               mm_reset_nxt = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_mm_host_controller.sv
// Bench for mm_host_controller: behavioural multiplier plus a directed and randomized
// job sequence checked against C = A*B computed from the words the bench sent.
module tb_mm_host_controller;

  localparam int TN = 2;
  localparam int NN = TN * TN;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [31:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] mm_data_in;
  logic [11:0] mm_address;
  logic        mm_write_enable;
  logic        mm_reset;
  logic [31:0] mm_data_out = '0;
  logic        mm_result_ready;
  logic        busy;
  logic        done;
  logic        timeout_err;

  int checks = 0;
  int failures = 0;

  mm_host_controller #(.N(TN), .DATA_W(32), .ADDR_W(12), .TIMEOUT(20)) dut (
    .clk(clk), .reset(reset), .start(start),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .mm_data_in(mm_data_in), .mm_address(mm_address),
    .mm_write_enable(mm_write_enable), .mm_reset(mm_reset),
    .mm_data_out(mm_data_out), .mm_result_ready(mm_result_ready),
    .busy(busy), .done(done), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  // Behavioural multiplier: memory with one-cycle read, result ready 10 cycles after release.
  logic [31:0] mem [0:4095];
  int          run_cnt = 0;
  logic        model_ready = 1'b0;
  logic        never_ready = 1'b0;
  logic        force_ready = 1'b0;

  assign mm_result_ready = model_ready | force_ready;

  function automatic logic [31:0] model_product(input int idx);
    logic [31:0] s = 0;
    for (int m = 0; m < TN; m++)
      s += mem[(idx / TN) * TN + m] * mem[NN + m * TN + (idx % TN)];
    return s;
  endfunction

  always @(posedge clk) begin
    if (mm_write_enable) mem[mm_address] <= mm_data_in;
    mm_data_out <= mem[mm_address];
    if (mm_reset) begin
      run_cnt     <= 0;
      model_ready <= 1'b0;
    end else if (!model_ready && !never_ready) begin
      if (run_cnt == 10) begin
        for (int i = 0; i < NN; i++) mem[2 * NN + i] <= model_product(i);
        model_ready <= 1'b1;
      end else begin
        run_cnt <= run_cnt + 1;
      end
    end
  end

  // Cumulative observations; each job snapshots the counts at its start.
  logic [11:0] wr_addr [$];
  logic [31:0] wr_data [$];
  logic [31:0] outs [$];
  int cyc = 0, done_cnt = 0, done_cyc = 0, last_hs_cyc = 0, fall_cyc = 0;
  int valid_cycles = 0, stab_errs = 0, busy_errs = 0, first_valid_cyc = 0, rr_rise_cyc = 0;

  initial begin
    logic        prev_valid = 1'b0, prev_acc = 1'b0, prev_done = 1'b0;
    logic        prev_mmr = 1'b1, prev_rr = 1'b0, pending = 1'b0;
    logic [31:0] prev_data = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (mm_write_enable) begin
        wr_addr.push_back(mm_address);
        wr_data.push_back(mm_data_in);
      end
      if (prev_valid && !prev_acc && (!out_valid || out_data !== prev_data)) stab_errs++;
      if (out_valid) valid_cycles++;
      if (out_valid && !prev_valid && pending) begin
        first_valid_cyc = cyc;
        pending = 1'b0;
      end
      if (mm_result_ready && !prev_rr) begin
        rr_rise_cyc = cyc;
        pending = 1'b1;
      end
      if (out_valid && out_ready) begin
        outs.push_back(out_data);
        last_hs_cyc = cyc;
      end
      if (prev_done && busy) busy_errs++;
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (prev_mmr && !mm_reset) fall_cyc = cyc;
      prev_valid = out_valid;
      prev_acc   = out_valid & out_ready;
      prev_data  = out_data;
      prev_done  = done;
      prev_mmr   = mm_reset;
      prev_rr    = mm_result_ready;
    end
  end

  // Consumer: 0 always ready, 1 holds each word off for 5 cycles, 2 random.
  int cons_mode = 0;
  initial begin
    int hold = 0;
    forever begin
      @(posedge clk);
      #1;
      case (cons_mode)
        0: out_ready = 1'b1;
        1: begin
          if (out_valid) begin
            if (hold < 5) begin
              out_ready = 1'b0;
              hold++;
            end else begin
              out_ready = 1'b1;
            end
          end else begin
            out_ready = 1'b0;
            hold = 0;
          end
        end
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic checkResetValues(input string pfx);
    checkOutput({pfx, "_in_ready"}, in_ready, 0);
    checkOutput({pfx, "_out_valid"}, out_valid, 0);
    checkOutput({pfx, "_out_data"}, out_data, 0);
    checkOutput({pfx, "_mm_data_in"}, mm_data_in, 0);
    checkOutput({pfx, "_mm_address"}, mm_address, 0);
    checkOutput({pfx, "_mm_we"}, mm_write_enable, 0);
    checkOutput({pfx, "_mm_reset"}, mm_reset, 1);
    checkOutput({pfx, "_busy"}, busy, 0);
    checkOutput({pfx, "_done"}, done, 0);
    checkOutput({pfx, "_timeout_err"}, timeout_err, 0);
  endtask

  logic [31:0] mat_a [NN];
  logic [31:0] mat_b [NN];

  function automatic logic [31:0] expected_c(input int idx);
    logic [31:0] s = 0;
    for (int m = 0; m < TN; m++) s += mat_a[(idx / TN) * TN + m] * mat_b[m * TN + (idx % TN)];
    return s;
  endfunction

  function automatic logic [31:0] operand_word(input int i);
    return (i < NN) ? mat_a[i] : mat_b[i - NN];
  endfunction

  // Presents one word, optionally after an idle cycle, and holds it until accepted.
  task automatic sendWord(input logic [31:0] w, input bit gap);
    bit acc = 1'b0;
    int t = 0;
    if (gap) begin
      in_valid = 1'b0;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b1;
    in_data  = w;
    while (!acc && t < 50) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      t++;
    end
    if (!acc) checkOutput("in_accept", 0, 1);
    in_valid = 1'b0;
  endtask

  task automatic pulseStart();
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // gap_mode: 0 back-to-back, 1 idle cycle before each word, 2 random idle cycles.
  task automatic applyStimulus(input string name, input int gap_mode, input int cmode,
                               input bit extra_valid, input bit force_rr,
                               input bit start_in_wait, input bit expect_timeout,
                               input bit check_latency);
    int w_base = wr_addr.size();
    int o_base = outs.size();
    int d_base = done_cnt;
    int s_base = stab_errs;
    int b_base = busy_errs;
    int v_base = valid_cycles;
    int t = 0;
    cons_mode = cmode;
    pulseStart();
    checkOutput({name, "_in_ready_after_start"}, in_ready, 1);
    checkOutput({name, "_err_cleared"}, timeout_err, 0);
    force_ready = force_rr;
    for (int i = 0; i < 2 * NN; i++) begin
      bit g = (gap_mode == 1) ? 1'b1 : (gap_mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
      sendWord(operand_word(i), g);
    end
    checkOutput({name, "_in_ready_drop"}, in_ready, 0);
    force_ready = 1'b0;
    if (extra_valid) begin
      in_valid = 1'b1;
      in_data  = 32'hDEAD_BEEF;
      repeat (3) @(posedge clk);
      #1 in_valid = 1'b0;
    end
    if (start_in_wait) begin
      repeat (2) @(posedge clk);
      #1 start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
    end
    while (done_cnt == d_base && t < 3000) begin
      @(negedge clk);
      t++;
    end
    if (done_cnt == d_base) checkOutput({name, "_done_wait"}, 0, 1);
    repeat (3) @(negedge clk);
    checkOutput({name, "_done_pulses"}, done_cnt - d_base, 1);
    checkOutput({name, "_busy_idle"}, busy, 0);
    checkOutput({name, "_busy_after_done"}, busy_errs - b_base, 0);
    checkOutput({name, "_timeout_err"}, timeout_err, expect_timeout);
    checkOutput({name, "_write_count"}, wr_addr.size() - w_base, 2 * NN);
    for (int i = 0; i < 2 * NN && w_base + i < wr_addr.size(); i++) begin
      checkOutput($sformatf("%s_waddr%0d", name, i), wr_addr[w_base + i], i);
      checkOutput($sformatf("%s_wdata%0d", name, i), wr_data[w_base + i], operand_word(i));
    end
    if (expect_timeout) begin
      checkOutput({name, "_timeout_latency"}, done_cyc - fall_cyc, 21);
      checkOutput({name, "_mm_reset_back"}, mm_reset, 1);
      checkOutput({name, "_no_valid"}, valid_cycles - v_base, 0);
      checkOutput({name, "_no_outputs"}, outs.size() - o_base, 0);
    end else begin
      checkOutput({name, "_out_count"}, outs.size() - o_base, NN);
      for (int i = 0; i < NN && o_base + i < outs.size(); i++)
        checkOutput($sformatf("%s_c%0d", name, i), outs[o_base + i], expected_c(i));
      checkOutput({name, "_done_latency"}, done_cyc - last_hs_cyc, 1);
      checkOutput({name, "_stable"}, stab_errs - s_base, 0);
      if (check_latency) checkOutput({name, "_rr_to_valid"}, first_valid_cyc - rr_rise_cyc, 3);
    end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 checkResetValues("reset");
    reset = 1'b0;

    mat_a = '{1, 0, 0, 1};
    mat_b = '{2, 3, 4, 5};
    applyStimulus("basic", 0, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);

    mat_a = '{1, 2, 3, 4};
    mat_b = '{5, 6, 7, 8};
    applyStimulus("gapped", 1, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus("backpressure", 0, 1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    never_ready = 1'b1;
    applyStimulus("timeout", 0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    never_ready = 1'b0;
    mat_a = '{3, 1, 4, 1};
    mat_b = '{5, 9, 2, 6};
    applyStimulus("after_timeout", 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    pulseStart();
    for (int i = 0; i < 3; i++) sendWord(32'(100 + i), 1'b0);
    @(posedge clk);
    #2 reset = 1'b1;
    #1 checkResetValues("midload");
    @(posedge clk);
    #1 reset = 1'b0;
    mat_a = '{7, 8, 9, 10};
    mat_b = '{11, 12, 13, 14};
    applyStimulus("after_reset", 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    applyStimulus("ignored_inputs", 0, 0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);

    for (int j = 0; j < 3; j++) begin
      for (int i = 0; i < NN; i++) begin
        mat_a[i] = $urandom();
        mat_b[i] = $urandom();
      end
      applyStimulus($sformatf("random%0d", j), 2, 2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
